// File: rtl/alu_seq.sv
// Handshaked ALU with registered results: single-cycle logic/arith/shift ops,
// iterative shift-add multiply and restoring unsigned divide/modulo.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             error
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;
    localparam logic [3:0] OP_MOD = 4'd9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_nx;
    logic [CW-1:0]   cnt_q;
    logic            rdy_q;
    logic            accept, is_iter, last_iter;

    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi_nx, lo_nx;

    logic [WIDTH-1:0] res_q, res_hi_q;
    logic             carry_q, ovf_q, err_q;

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_c, sc_v, sc_err;
    logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w;
    logic [SW-1:0]    sh;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign in_ready  = rdy_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign is_iter   = (op_code == OP_MUL) ||
                       (((op_code == OP_DIV) || (op_code == OP_MOD)) && (B != '0));
    assign last_iter = (state_q == BUSY) && (cnt_q == LAST);

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: if (accept) state_nx = is_iter ? BUSY : DONE;
            BUSY: if (cnt_q == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath, evaluated directly on the live operands at accept
    assign sh    = B[SW-1:0];
    assign sum_w = {1'b0, A} + {1'b0, B};
    assign dif_w = {1'b0, A} - {1'b0, B};
    assign shl_w = {1'b0, A} << sh;
    assign shr_w = {A, 1'b0} >> sh;

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (op_code)
            OP_ADD: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = add_ovf(A, B, sum_w[WIDTH-1:0]);
            end
            OP_SUB: begin
                sc_res = dif_w[WIDTH-1:0];
                sc_c   = dif_w[WIDTH];
                sc_v   = sub_ovf(A, B, dif_w[WIDTH-1:0]);
            end
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_XOR: sc_res = A ^ B;
            OP_SHL: begin
                sc_res = shl_w[WIDTH-1:0];
                sc_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_w[WIDTH:1];
                sc_c   = shr_w[0];
            end
            OP_MUL: ;
            // Only reached here with a zero divisor; non-zero divisors iterate
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = A;
                sc_v   = 1'b1;
            end
            OP_MOD: begin
                sc_res = A;
                sc_hi  = '1;
                sc_v   = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // Iterative datapath: hi/lo hold product halves for MUL, remainder/quotient for DIV
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;

    always_comb begin
        hi_nx = hi_q;
        lo_nx = lo_q;
        if (op_q == OP_MUL) begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (div_ge) begin
            hi_nx = div_diff;
            lo_nx = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx = div_shift[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_code;
            hi_q <= '0;
            lo_q <= (op_code == OP_MUL) ? B : A;
        end else if (state_q == BUSY) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
        end
    end

    // Control and result registers; results only load on completion so DONE holds them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            rdy_q   <= 1'b1;
            if (accept)
                cnt_q <= '0;
            else if (state_q == BUSY)
                cnt_q <= cnt_q + CW'(1);
            if (accept && !is_iter) begin
                res_q    <= sc_res;
                res_hi_q <= sc_hi;
                carry_q  <= sc_c;
                ovf_q    <= sc_v;
                err_q    <= sc_err;
            end else if (last_iter) begin
                res_q    <= (op_q == OP_MOD) ? hi_nx : lo_nx;
                res_hi_q <= (op_q == OP_MOD) ? lo_nx : hi_nx;
                carry_q  <= (op_q == OP_MUL) && (hi_nx != '0);
                ovf_q    <= (op_q == OP_MUL) && (hi_nx != '0);
                err_q    <= 1'b0;
            end
        end
    end

    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = (res_q == '0);
    assign negative  = res_q[WIDTH-1];
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign error     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   op_code = '0;
    logic         in_ready, out_valid, zero, negative, carry, overflow, error;
    logic [W-1:0] result, result_hi;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] rh;
        logic       z, n, c, v, e;
        logic [7:0] lat;
    } exp_t;

    function automatic exp_t model(input int op, input int a, input int b);
        exp_t x;
        int sa, sb, s, r, rh, sh;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        r = 0; rh = 0;
        x.c = 0; x.v = 0; x.e = 0; x.lat = 1;
        case (op)
            0: begin s = a + b; r = s % 256; x.c = (s > 255); x.v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = (a - b + 256) % 256; x.c = (a < b); x.v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << sh) % 256; x.c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
            6: begin r = a >> sh; x.c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            7: begin s = a * b; r = s % 256; rh = s / 256; x.c = (rh != 0); x.v = (rh != 0); x.lat = 9; end
            8, 9: begin
                if (b == 0) begin r = 255; rh = a; x.v = 1; end
                else begin r = a / b; rh = a % b; x.lat = 9; end
                if (op == 9) begin s = r; r = rh; rh = s; end
            end
            default: x.e = 1;
        endcase
        x.r = 8'(r);
        x.rh = 8'(rh);
        x.z = (r == 0);
        x.n = (r >= 128);
        return x;
    endfunction

    task automatic do_op(input int op, input int a, input int b, input int hold, input string tag);
        exp_t x;
        int cyc;
        x = model(op, a, b);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
        else n_pass++;
        A = 8'(a); B = 8'(b); op_code = 4'(op); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL %s in_ready_busy: got %b want 0", tag, in_ready);
            else n_pass++;
            A = 8'($urandom); B = 8'($urandom); op_code = 4'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != int'(x.lat)) $display("FAIL %s latency: got %0d want %0d", tag, cyc, x.lat);
        else n_pass++;
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL %s handshake_done: got out_valid=%b in_ready=%b want 1/0", tag, out_valid, in_ready);
            else n_pass++;
            n_checks++;
            if (result !== x.r || result_hi !== x.rh)
                $display("FAIL %s result: got %h/%h want %h/%h (a=%0d b=%0d)", tag, result, result_hi, x.r, x.rh, a, b);
            else n_pass++;
            n_checks++;
            if ({zero, negative, carry, overflow, error} !== {x.z, x.n, x.c, x.v, x.e})
                $display("FAIL %s flags zncve: got %b want %b (a=%0d b=%0d)", tag,
                         {zero, negative, carry, overflow, error}, {x.z, x.n, x.c, x.v, x.e}, a, b);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
        if (result !== 8'h00 || result_hi !== 8'h00 || {carry, overflow, error} !== 3'b000)
            $display("FAIL reset_out: got %h/%h cve=%b want 0", result, result_hi, {carry, overflow, error});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        do_op(0, 100, 55, 0, "add_100_55");
        do_op(1, 30, 100, 0, "sub_30_100");
        do_op(7, 15, 15, 0, "mul_15_15");
        do_op(7, 200, 200, 0, "mul_200_200");
        do_op(8, 200, 7, 0, "div_200_7");
        do_op(9, 200, 7, 0, "mod_200_7");
        do_op(8, 77, 0, 0, "div_by_0");
        do_op(9, 77, 0, 0, "mod_by_0");
        do_op(5, 8'h81, 1, 0, "shl_81_1");
        do_op(6, 8'h03, 0, 0, "shr_03_0");
        do_op(15, 12, 34, 0, "illegal_f");
        do_op(7, 255, 255, 0, "mul_max");
        do_op(0, 255, 1, 0, "add_wrap");
    endtask

    task automatic test_backpressure();
        do_op(7, 200, 200, 3, "bp_mul");
        do_op(1, 30, 100, 3, "bp_sub");
        do_op(9, 250, 13, 2, "bp_mod");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            do_op(i % 7, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, "b2b");
    endtask

    task automatic test_random();
        int op, a, b;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(op, a, b, int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        do_op(0, 100, 55, 0, "pre_reset_add");
        @(negedge clk);
        A = 8'd200; B = 8'd200; op_code = 4'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL busy4_state: got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (result !== 8'h00 || result_hi !== 8'h00 || {zero, negative, carry, overflow, error} !== 5'b10000)
            $display("FAIL rst_busy_out: got %h/%h zncve=%b want 00/00 10000", result, result_hi,
                     {zero, negative, carry, overflow, error});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_busy_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_busy_no_valid: got %b want 0", out_valid);
        else n_pass++;
        do_op(0, 1, 1, 0, "add_after_reset");

        // Reset while a DIV result sits unconsumed in DONE
        @(negedge clk);
        A = 8'd200; B = 8'd7; op_code = 4'd8; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rst_done_timeout: got out_valid=%b want 1", out_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00)
            $display("FAIL rst_done_out: got out_valid=%b %h/%h want 0 00/00", out_valid, result, result_hi);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_done_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        do_op(9, 200, 7, 0, "mod_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
